busgh_rx: RTL and testbench

BUSGH_RX -- requirements
Module: busgh_rx

---
 rtl/busgh_rx.sv | 169 ++++++++++++++++
 tb/tb_busgh_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/busgh_rx.sv
// G-bus byte receiver with strobe-width/stability checking, FWFT receive FIFO,
// and an H-bus config register using the same strobe qualification.
module busgh_rx #(
  parameter int GDELAY = 4,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] g,
  input  logic [2:0] gc,
  input  logic [7:0] h,
  input  logic [2:0] hc,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] cfg,
  output logic       cfg_valid,
  output logic       err_strobe,
  output logic       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(GDELAY + 1);

  typedef enum logic {GIDLE, GSTB} g_state_t;
  typedef enum logic {HIDLE, HSTB} h_state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CW'(GDELAY)) ? CW'(GDELAY) : c + 1'b1;
  endfunction

  logic unused_ctrl;
  assign unused_ctrl = ^{gc[2:1], hc[1:0]};

  g_state_t       g_state, g_state_nxt;
  logic           g_start, g_end, g_legal, g_block, g_mis;
  logic [CW-1:0]  g_cnt;
  logic [7:0]     g_hold;

  h_state_t       h_state, h_state_nxt;
  logic           h_start, h_end, h_legal, h_block, h_mis;
  logic [CW-1:0]  h_cnt;
  logic [7:0]     h_hold;

  logic           vld_p0;
  logic [7:0]     data_p0;

  logic [7:0]     mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           full, empty, pop, wr_en;

  // Strobe decode: a strobe is judged on the cycle it is sampled low
  always_comb begin
    g_state_nxt = g_state;
    g_start     = 1'b0;
    g_end       = 1'b0;
    case (g_state)
      GIDLE: if (gc[0] && !g_block) begin
        g_state_nxt = GSTB;
        g_start     = 1'b1;
      end
      GSTB: if (!gc[0]) begin
        g_state_nxt = GIDLE;
        g_end       = 1'b1;
      end
      default: g_state_nxt = GIDLE;
    endcase
  end

  always_comb begin
    h_state_nxt = h_state;
    h_start     = 1'b0;
    h_end       = 1'b0;
    case (h_state)
      HIDLE: if (hc[2] && !h_block) begin
        h_state_nxt = HSTB;
        h_start     = 1'b1;
      end
      HSTB: if (!hc[2]) begin
        h_state_nxt = HIDLE;
        h_end       = 1'b1;
      end
      default: h_state_nxt = HIDLE;
    endcase
  end

  assign g_legal = g_end && (g_cnt == CW'(GDELAY - 1)) && !g_mis;
  assign h_legal = h_end && (h_cnt == CW'(GDELAY - 1)) && !h_mis;

  // A strobe already high during reset must fall before the path re-arms
  always_ff @(posedge clk) begin
    if (rst) begin
      g_state <= GIDLE;
      h_state <= HIDLE;
      g_block <= gc[0];
      h_block <= hc[2];
    end else begin
      g_state <= g_state_nxt;
      h_state <= h_state_nxt;
      if (!gc[0]) g_block <= 1'b0;
      if (!hc[2]) h_block <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (g_start) begin
      g_cnt  <= CW'(1);
      g_hold <= g;
      g_mis  <= 1'b0;
    end else if (g_state == GSTB && gc[0]) begin
      g_cnt <= sat_inc(g_cnt);
      if (g != g_hold) g_mis <= 1'b1;
    end
    if (h_start) begin
      h_cnt  <= CW'(1);
      h_hold <= h;
      h_mis  <= 1'b0;
    end else if (h_state == HSTB && hc[2]) begin
      h_cnt <= sat_inc(h_cnt);
      if (h != h_hold) h_mis <= 1'b1;
    end
  end

  // Stage p0: accepted G byte waiting to enter the FIFO
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= g_legal;
    data_p0 <= g_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg        <= 8'h00;
      cfg_valid  <= 1'b0;
      err_strobe <= 1'b0;
    end else begin
      err_strobe <= (g_end && !g_legal) || (h_end && !h_legal);
      if (h_legal) begin
        cfg       <= h_hold;
        cfg_valid <= 1'b1;
      end
    end
  end

  // FIFO: a full FIFO still takes a push when the head is popped in the same cycle
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid && out_ready;
  assign wr_en     = vld_p0 && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (vld_p0 && full && !pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr[AW-1:0]] <= data_p0;
  end

endmodule

// File: tb/tb_busgh_rx.sv
// Bench for busgh_rx: directed vector table, hand-written FIFO/config sequences,
// and randomized strobes checked every cycle against a queue-based model.
module tb_busgh_rx;

  localparam int GDELAY = 4;
  localparam int DEPTH  = 4;

  typedef logic [7:0] byte_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] g = 8'h00, h = 8'h00;
  logic [2:0] gc = 3'b000, hc = 3'b000;
  logic       out_ready = 1'b0;
  logic [7:0] out_data, cfg;
  logic       out_valid, cfg_valid, err_strobe, ovf;

  int nchk = 0;
  int nerr = 0;

  busgh_rx #(.GDELAY(GDELAY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .g(g), .gc(gc), .h(h), .hc(hc),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg(cfg), .cfg_valid(cfg_valid), .err_strobe(err_strobe), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: strobe contents collected in queues, judged when the strobe falls
  byte_t m_q[$];
  byte_t m_gh[$];
  byte_t m_hh[$];
  bit    m_gblk, m_hblk, m_pend, m_cfgv, m_err, m_ovf;
  byte_t m_pend_d, m_cfg;

  function automatic bit legal(input byte_t q[$]);
    if (q.size() != GDELAY - 1) return 1'b0;
    foreach (q[i]) if (q[i] != q[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input bit rs, input bit gs, input byte_t gv,
                       input bit hs, input byte_t hv, input bit rdy);
    bit pop, npend, ge, he;
    byte_t nd;
    int sz;
    if (rs) begin
      m_q.delete(); m_gh.delete(); m_hh.delete();
      m_gblk = gs; m_hblk = hs; m_pend = 0;
      m_cfg = 8'h00; m_cfgv = 0; m_err = 0; m_ovf = 0;
      return;
    end
    sz = m_q.size();
    pop = (sz != 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (m_pend) begin
      if (sz == DEPTH && !pop) m_ovf = 1;
      else m_q.push_back(m_pend_d);
    end
    npend = 0; nd = 8'h00; ge = 0; he = 0;
    if (gs) begin
      if (!m_gblk) m_gh.push_back(gv);
    end else begin
      if (m_gh.size() != 0) begin
        if (legal(m_gh)) begin npend = 1; nd = m_gh[0]; end
        else ge = 1;
        m_gh.delete();
      end
      m_gblk = 0;
    end
    if (hs) begin
      if (!m_hblk) m_hh.push_back(hv);
    end else begin
      if (m_hh.size() != 0) begin
        if (legal(m_hh)) begin m_cfg = m_hh[0]; m_cfgv = 1; end
        else he = 1;
        m_hh.delete();
      end
      m_hblk = 0;
    end
    m_err = ge | he;
    m_pend = npend;
    m_pend_d = nd;
  endtask

  task automatic cyc(input bit rs, input bit gs, input byte_t gv,
                     input bit hs, input byte_t hv, input bit rdy);
    rst = rs;
    gc = {2'($urandom), gs};
    hc = {hs, 2'($urandom)};
    g = gv;
    h = hv;
    out_ready = rdy;
    @(posedge clk);
    model(rs, gs, gv, hs, hv, rdy);
    #1;
    chk("m_out_valid", out_valid, (m_q.size() != 0));
    if (m_q.size() != 0) chk("m_out_data", out_data, m_q[0]);
    chk("m_cfg", cfg, m_cfg);
    chk("m_cfg_valid", cfg_valid, m_cfgv);
    chk("m_err_strobe", err_strobe, m_err);
    chk("m_ovf", ovf, m_ovf);
  endtask

  task automatic strobe(input byte_t b, input bit rdy);
    for (int i = 0; i < GDELAY - 1; i++) cyc(0, 1, b, 0, 8'h00, rdy);
    cyc(0, 0, b, 0, 8'h00, rdy);
  endtask

  typedef struct {
    bit    gs;
    byte_t gv;
    bit    rdy;
    bit    ev;
    byte_t ed;
    bit    ee;
  } vec_t;

  vec_t tbl [21];

  initial begin
    byte_t exp_d [4];
    tbl[0]  = '{1, 8'hA5, 0, 0, 8'h00, 0};
    tbl[1]  = '{1, 8'hA5, 0, 0, 8'h00, 0};
    tbl[2]  = '{1, 8'hA5, 0, 0, 8'h00, 0};
    tbl[3]  = '{0, 8'hA5, 0, 0, 8'h00, 0};
    tbl[4]  = '{0, 8'h00, 1, 1, 8'hA5, 0};
    tbl[5]  = '{0, 8'h00, 1, 0, 8'h00, 0};
    tbl[6]  = '{1, 8'h33, 1, 0, 8'h00, 0};
    tbl[7]  = '{1, 8'h33, 1, 0, 8'h00, 0};
    tbl[8]  = '{0, 8'h33, 1, 0, 8'h00, 1};
    tbl[9]  = '{0, 8'h00, 1, 0, 8'h00, 0};
    tbl[10] = '{1, 8'h44, 1, 0, 8'h00, 0};
    tbl[11] = '{1, 8'h44, 1, 0, 8'h00, 0};
    tbl[12] = '{1, 8'h44, 1, 0, 8'h00, 0};
    tbl[13] = '{1, 8'h44, 1, 0, 8'h00, 0};
    tbl[14] = '{0, 8'h44, 1, 0, 8'h00, 1};
    tbl[15] = '{0, 8'h00, 1, 0, 8'h00, 0};
    tbl[16] = '{1, 8'h11, 1, 0, 8'h00, 0};
    tbl[17] = '{1, 8'h12, 1, 0, 8'h00, 0};
    tbl[18] = '{1, 8'h12, 1, 0, 8'h00, 0};
    tbl[19] = '{0, 8'h12, 1, 0, 8'h00, 1};
    tbl[20] = '{0, 8'h00, 1, 0, 8'h00, 0};

    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cfg", cfg, 8'h00);
    chk("rst_cfg_valid", cfg_valid, 1'b0);
    chk("rst_err", err_strobe, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    cyc(0, 0, 8'h00, 0, 8'h00, 0);

    foreach (tbl[i]) begin
      cyc(0, tbl[i].gs, tbl[i].gv, 0, 8'h00, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("vec%0d_err", i), err_strobe, tbl[i].ee);
      chk($sformatf("vec%0d_ovf", i), ovf, 1'b0);
    end

    // Overflow: five bytes into a four-deep FIFO, then drain
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    for (int b = 1; b <= 5; b++) strobe(byte_t'(b), 0);
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("ovf_set", ovf, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain_valid", out_valid, 1'b1);
      chk($sformatf("ovf_drain_data%0d", k), out_data, k);
      cyc(0, 0, 8'h00, 0, 8'h00, 1);
    end
    chk("ovf_drain_empty", out_valid, 1'b0);

    // Push and pop in the same cycle while full
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    for (int b = 1; b <= 4; b++) strobe(byte_t'(b), 0);
    strobe(8'h77, 0);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("fullpp_ovf", ovf, 1'b0);
    exp_d = '{8'h02, 8'h03, 8'h04, 8'h77};
    for (int k = 0; k < 4; k++) begin
      chk("fullpp_valid", out_valid, 1'b1);
      chk($sformatf("fullpp_data%0d", k), out_data, exp_d[k]);
      cyc(0, 0, 8'h00, 0, 8'h00, 1);
    end
    chk("fullpp_empty", out_valid, 1'b0);

    // Config path and its reset
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < GDELAY - 1; i++) cyc(0, 0, 8'h00, 1, 8'h09, 0);
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("cfg_value", cfg, 8'h09);
    chk("cfg_valid_set", cfg_valid, 1'b1);
    chk("cfg_err", err_strobe, 1'b0);
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    chk("cfg_rst_value", cfg, 8'h00);
    chk("cfg_rst_valid", cfg_valid, 1'b0);

    // Reset mid-strobe: the strobe still high afterwards is ignored
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
    cyc(0, 1, 8'h55, 0, 8'h00, 1);
    cyc(0, 1, 8'h55, 0, 8'h00, 1);
    cyc(1, 1, 8'h55, 0, 8'h00, 1);
    for (int i = 0; i < GDELAY - 1; i++) cyc(0, 1, 8'h55, 0, 8'h00, 1);
    cyc(0, 0, 8'h55, 0, 8'h00, 1);
    chk("midrst_err", err_strobe, 1'b0);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    chk("midrst_valid", out_valid, 1'b0);

    // Randomized traffic on both buses
    for (int n = 0; n < 400; n++) begin
      int len, gap;
      byte_t b;
      len = $urandom_range(1, 5);
      gap = $urandom_range(1, 3);
      b = byte_t'($urandom_range(0, 255));
      for (int j = 0; j < len + gap; j++) begin
        bit rs, hs, rdy;
        byte_t gv, hv;
        rs = ($urandom_range(0, 199) == 0);
        gv = ($urandom_range(0, 9) == 0) ? (b ^ 8'h01) : b;
        hs = ($urandom_range(0, 3) != 0);
        hv = ($urandom_range(0, 7) == 0) ? 8'h5A : 8'h3C;
        rdy = ($urandom_range(0, 3) < ((n < 200) ? 1 : 3));
        cyc(rs, (j < len), gv, hs, hv, rdy);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
